pe_row_sequencer: RTL
=====================

PE_ROW_SEQUENCER -- requirements
Module: pe_row_sequencer

Interface
REQ-001 Parameter DEPTH_F, default 5: filter taps per PE row.
REQ-002 Parameter DEPTH_I, default 25: ifmap words per PE row.
REQ-003 Parameter DEPTH_R, default 21: output psums per row; SHALL equal DEPTH_I-DEPTH_F+1.
REQ-004 Parameter ADDR_F, default 3: filter address width.
REQ-005 Parameter ADDR_I, default 5: ifmap address width; row_idx also uses this width.
REQ-006 clk  input  1  single clock; all state changes on the rising edge.
REQ-007 rst  input  1  reset, synchronous, active-high.
REQ-008 filter_wr  input  1  one filter word written to filter RF this cycle.
REQ-009 ifmap_wr  input  1  one ifmap word written to ifmap RF this cycle.
REQ-010 mac_valid  output  1  MAC beat offered.
REQ-011 mac_ready  input  1  datapath accepts MAC beat.
REQ-012 filter_addr  output  ADDR_F  filter RF read address for current beat.
REQ-013 ifmap_addr  output  ADDR_I  ifmap RF read address for current beat.
REQ-014 acc_clear  output  1  beat is first tap; accumulator starts from 0.
REQ-015 last_tap  output  1  beat is final tap of a row.
REQ-016 psum_valid  output  1  combine-with-incoming-psum step offered; doubles as add_sel.
REQ-017 psum_ready  input  1  psum combine/forward accepted.
REQ-018 row_idx  output  ADDR_I  output index i of current row.
REQ-019 busy  output  1  high in RUN and PSUM.
REQ-020 done  output  1  one-cycle pulse, all DEPTH_R rows finished.
REQ-021 load_err  output  1  one-cycle pulse, filter_wr or ifmap_wr outside IDLE.

Function
REQ-022 States SHALL be IDLE, RUN, PSUM, DONE; all outputs registered.
REQ-023 IDLE: fcnt increments on filter_wr and icnt on ifmap_wr, saturating at DEPTH_F / DEPTH_I; writes beyond saturation are ignored, no error.
REQ-024 IDLE->RUN on the edge after both fcnt==DEPTH_F and icnt==DEPTH_I hold; i=0, j=0; simultaneous final filter_wr and ifmap_wr in one cycle counts both.
REQ-025 RUN: mac_valid=1, filter_addr=j, ifmap_addr=i+j, acc_clear=(j==0), last_tap=(j==DEPTH_F-1), row_idx=i.
REQ-026 Beat transfers only when mac_valid&&mac_ready; while mac_ready=0, mac_valid and all beat fields SHALL hold stable.
REQ-027 On transfer with j<DEPTH_F-1: j increments, next beat presented the following cycle; with j==DEPTH_F-1: RUN->PSUM, mac_valid=0.
REQ-028 PSUM: psum_valid=1, row_idx=i, mac_valid=0; held stable until psum_ready.
REQ-029 On psum_valid&&psum_ready: if i<DEPTH_R-1 then i increments, j=0, ->RUN; if i==DEPTH_R-1 then ->DONE.
REQ-030 DONE: done=1 for exactly one cycle, then ->IDLE with fcnt=icnt=0; a fresh full load is required for the next pass.
REQ-031 filter_wr or ifmap_wr while in RUN, PSUM or DONE: load_err=1 on the next cycle, write not counted, sequencing unaffected.
REQ-032 ifmap_addr SHALL never exceed DEPTH_I-1; filter_addr never exceeds DEPTH_F-1.
REQ-033 With mac_ready and psum_ready held high: 6 cycles per row, 126 cycles from RUN entry to DONE (defaults).

Reset
REQ-034 rst high at an edge: state=IDLE, fcnt=icnt=i=j=0; mac_valid, psum_valid, acc_clear, last_tap, busy, done, load_err=0; filter_addr, ifmap_addr, row_idx=0.
REQ-035 rst mid-RUN or mid-PSUM SHALL abort the pass with no done pulse; held rst ignores filter_wr/ifmap_wr.

Verification
REQ-036 5 filter_wr + 25 ifmap_wr, readies high -> RUN one cycle later; 105 MAC beats, 21 psum beats, done pulse 126 cycles after RUN entry.
REQ-037 Row i=3 -> beats (filter_addr,ifmap_addr) = (0,3),(1,4),(2,5),(3,6),(4,7); acc_clear only on first, last_tap only on last; last row ifmap_addr ends at 24.
REQ-038 mac_ready low 4 cycles at j=2 of row 0 -> filter_addr=2, ifmap_addr=2 held; no beat skipped or repeated.
REQ-039 Only 24 ifmap_wr plus 5 filter_wr -> stays IDLE, busy=0; 25th ifmap_wr -> RUN next cycle; extra 6th filter_wr in IDLE ignored.
REQ-040 filter_wr during PSUM of row 7 -> load_err one cycle, row sequence continues with row 8.
REQ-041 rst at row 10 RUN -> all outputs 0 next cycle, IDLE, no done; reload 5+25 restarts at row 0.

Source files
------------

// File: rtl/pe_row_sequencer.sv
// Row-stationary PE sequencer: counts filter/ifmap loads, then walks every output
// row through DEPTH_F MAC beats plus one psum-combine step, with ready/valid handshakes.
module pe_row_sequencer #(
    parameter int DEPTH_F = 5,
    parameter int DEPTH_I = 25,
    parameter int DEPTH_R = 21,
    parameter int ADDR_F  = 3,
    parameter int ADDR_I  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              filter_wr,
    input  logic              ifmap_wr,
    output logic              mac_valid,
    input  logic              mac_ready,
    output logic [ADDR_F-1:0] filter_addr,
    output logic [ADDR_I-1:0] ifmap_addr,
    output logic              acc_clear,
    output logic              last_tap,
    output logic              psum_valid,
    input  logic              psum_ready,
    output logic [ADDR_I-1:0] row_idx,
    output logic              busy,
    output logic              done,
    output logic              load_err
);
    localparam int FC_W = $clog2(DEPTH_F + 1);
    localparam int IC_W = $clog2(DEPTH_I + 1);
    localparam logic [FC_W-1:0]   F_FULL = FC_W'(DEPTH_F);
    localparam logic [IC_W-1:0]   I_FULL = IC_W'(DEPTH_I);
    localparam logic [ADDR_F-1:0] J_LAST = ADDR_F'(DEPTH_F - 1);
    localparam logic [ADDR_I-1:0] R_LAST = ADDR_I'(DEPTH_R - 1);

    typedef enum logic [1:0] {IDLE, RUN, PSUM, DONE} state_t;

    state_t            state, state_n;
    logic [FC_W-1:0]   fcnt, fcnt_n;
    logic [IC_W-1:0]   icnt, icnt_n;
    logic [ADDR_I-1:0] i, i_n;
    logic [ADDR_F-1:0] j, j_n;

    // Next values of the registered outputs, decoded from the next state so the
    // outputs line up with the state they describe.
    logic              mac_valid_n, acc_clear_n, last_tap_n, psum_valid_n;
    logic              busy_n, done_n, load_err_n;
    logic [ADDR_F-1:0] filter_addr_n;
    logic [ADDR_I-1:0] ifmap_addr_n, row_idx_n;

    always_comb begin
        state_n = state;
        fcnt_n  = fcnt;
        icnt_n  = icnt;
        i_n     = i;
        j_n     = j;
        case (state)
            IDLE: begin
                if (fcnt == F_FULL && icnt == I_FULL) begin
                    state_n = RUN;
                    i_n     = '0;
                    j_n     = '0;
                end else begin
                    if (filter_wr && fcnt != F_FULL) fcnt_n = fcnt + 1'b1;
                    if (ifmap_wr && icnt != I_FULL)  icnt_n = icnt + 1'b1;
                end
            end
            RUN: begin
                if (mac_valid && mac_ready) begin
                    if (j == J_LAST) state_n = PSUM;
                    else             j_n     = j + 1'b1;
                end
            end
            PSUM: begin
                if (psum_valid && psum_ready) begin
                    if (i == R_LAST) begin
                        state_n = DONE;
                    end else begin
                        state_n = RUN;
                        i_n     = i + 1'b1;
                        j_n     = '0;
                    end
                end
            end
            DONE: begin
                state_n = IDLE;
                fcnt_n  = '0;
                icnt_n  = '0;
            end
            default: state_n = IDLE;
        endcase

        mac_valid_n   = (state_n == RUN);
        psum_valid_n  = (state_n == PSUM);
        busy_n        = mac_valid_n || psum_valid_n;
        done_n        = (state_n == DONE);
        filter_addr_n = mac_valid_n ? j_n : '0;
        ifmap_addr_n  = mac_valid_n ? (i_n + ADDR_I'(j_n)) : '0;
        acc_clear_n   = mac_valid_n && (j_n == '0);
        last_tap_n    = mac_valid_n && (j_n == J_LAST);
        row_idx_n     = busy_n ? i_n : '0;
        load_err_n    = (state != IDLE) && (filter_wr || ifmap_wr);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            fcnt        <= '0;
            icnt        <= '0;
            i           <= '0;
            j           <= '0;
            mac_valid   <= 1'b0;
            filter_addr <= '0;
            ifmap_addr  <= '0;
            acc_clear   <= 1'b0;
            last_tap    <= 1'b0;
            psum_valid  <= 1'b0;
            row_idx     <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            load_err    <= 1'b0;
        end else begin
            state       <= state_n;
            fcnt        <= fcnt_n;
            icnt        <= icnt_n;
            i           <= i_n;
            j           <= j_n;
            mac_valid   <= mac_valid_n;
            filter_addr <= filter_addr_n;
            ifmap_addr  <= ifmap_addr_n;
            acc_clear   <= acc_clear_n;
            last_tap    <= last_tap_n;
            psum_valid  <= psum_valid_n;
            row_idx     <= row_idx_n;
            busy        <= busy_n;
            done        <= done_n;
            load_err    <= load_err_n;
        end
    end
endmodule
